// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt controller.
// - irqc_state_t  : presentation/handshake state (IDLE, PRESENT, IN_SERVICE)
// - IRQ_CODE_NONE : code on `interrupt` when no request is presented
// - irq_code()    : maps a source index to its encoded request number
package interrupt_controller_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESENT    = 2'd1,
    IN_SERVICE = 2'd2
  } irqc_state_t;

  localparam int unsigned IRQ_CODE_NONE = 0;

  // Source i is reported as code i+1 so that 0 can mean "no request".
  function automatic int unsigned irq_code(input int unsigned idx);
    return idx + 1;
  endfunction

endpackage

// File: rtl/interrupt_controller_irq_edge_sync.sv
// irq_edge_sync: per-line input synchroniser and rising-edge detector.
// Configuration macro: IRQ_SYNC_EN
//   defined   - two-flop synchroniser followed by a delay flop
//   undefined - single input register followed by a delay flop
//               (for lines already synchronous to clk)
// Ports:
//   clk    in  : clock
//   rst_n  in  : asynchronous active-low reset (all flops to 0)
//   irq_in in  : raw request line
//   rise   out : one-cycle pulse on a synchronised 0->1 transition
module irq_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic irq_in,
  output logic rise
);

  logic sync_q;
  logic dly_q;

`ifdef IRQ_SYNC_EN
  logic meta_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= irq_in;
      sync_q <= meta_q;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 1'b0;
    end else begin
      sync_q <= irq_in;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_q <= 1'b0;
    end else begin
      dly_q <= sync_q;
    end
  end

  assign rise = sync_q & ~dly_q;

endmodule

// File: rtl/interrupt_controller.sv
// interrupt_controller: latches rising edges of external interrupt lines as
// pending requests, masks them, and presents the highest-priority (lowest
// index) eligible request to the control FSM as an encoded number held
// stable until the FSM's processing_interrupt handshake completes.
// Configuration macro: IRQ_SYNC_EN (see irq_edge_sync; adds one cycle of
// input latency when defined).
// Parameters:
//   INTERRUPT_WIDTH : width of `interrupt`
//   NUM_SOURCES     : number of request lines (1 .. 2**INTERRUPT_WIDTH-1)
// Ports:
//   clk                  in  : clock
//   rst_n                in  : asynchronous active-low reset
//   irq_in               in  : raw request lines, rising-edge triggered
//   processing_interrupt in  : FSM handshake (high = acknowledged/in handler)
//   mask_we              in  : mask write strobe
//   mask_data            in  : new mask value (1 = enabled)
//   interrupt            out : presented code (0 = none, source i -> i+1)
//   pending              out : latched, unserviced edges
//   mask                 out : current enable mask
//   in_service           out : high while an acknowledged interrupt is handled
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int unsigned INTERRUPT_WIDTH = 4,
  parameter int unsigned NUM_SOURCES     = 15
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_SOURCES-1:0]     irq_in,
  input  logic                       processing_interrupt,
  input  logic                       mask_we,
  input  logic [NUM_SOURCES-1:0]     mask_data,
  output logic [INTERRUPT_WIDTH-1:0] interrupt,
  output logic [NUM_SOURCES-1:0]     pending,
  output logic [NUM_SOURCES-1:0]     mask,
  output logic                       in_service
);

  localparam logic [INTERRUPT_WIDTH-1:0] CODE_NONE = INTERRUPT_WIDTH'(IRQ_CODE_NONE);

  irqc_state_t                state_q, state_d;
  logic [NUM_SOURCES-1:0]     rise;
  logic [NUM_SOURCES-1:0]     eligible;
  logic [NUM_SOURCES-1:0]     ack_clr;
  logic [NUM_SOURCES-1:0]     clr;
  logic [NUM_SOURCES-1:0]     pending_d;
  logic [NUM_SOURCES-1:0]     mask_d;
  logic [INTERRUPT_WIDTH-1:0] sel_code;
  logic [INTERRUPT_WIDTH-1:0] interrupt_d;
  logic                       in_service_d;

  for (genvar g = 0; g < NUM_SOURCES; g++) begin : g_line
    irq_edge_sync u_edge (
      .clk    (clk),
      .rst_n  (rst_n),
      .irq_in (irq_in[g]),
      .rise   (rise[g])
    );
  end

  assign eligible = pending & mask;

  // Scan from the top down so the lowest eligible index is the last write.
  always_comb begin
    sel_code = CODE_NONE;
    for (int unsigned i = NUM_SOURCES; i > 0; i--) begin
      if (eligible[i-1]) begin
        sel_code = INTERRUPT_WIDTH'(irq_code(i - 1));
      end
    end
  end

  // One-hot of the source whose code is currently presented.
  always_comb begin
    ack_clr = '0;
    for (int unsigned i = 0; i < NUM_SOURCES; i++) begin
      ack_clr[i] = (interrupt == INTERRUPT_WIDTH'(irq_code(i)));
    end
  end

  always_comb begin
    state_d      = state_q;
    interrupt_d  = interrupt;
    in_service_d = in_service;
    clr          = '0;
    unique case (state_q)
      IDLE: begin
        interrupt_d  = CODE_NONE;
        in_service_d = 1'b0;
        if (!processing_interrupt && (|eligible)) begin
          interrupt_d = sel_code;
          state_d     = PRESENT;
        end
      end
      PRESENT: begin
        in_service_d = 1'b0;
        if (processing_interrupt) begin
          clr          = ack_clr;
          in_service_d = 1'b1;
          state_d      = IN_SERVICE;
        end
      end
      IN_SERVICE: begin
        in_service_d = 1'b1;
        if (!processing_interrupt) begin
          interrupt_d  = CODE_NONE;
          in_service_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d      = IDLE;
        interrupt_d  = CODE_NONE;
        in_service_d = 1'b0;
      end
    endcase
    // A new edge in the same cycle as the acknowledge clear keeps the bit set.
    pending_d = (pending & ~clr) | rise;
    mask_d    = mask_we ? mask_data : mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      interrupt  <= CODE_NONE;
      pending    <= '0;
      mask       <= '0;
      in_service <= 1'b0;
    end else begin
      state_q    <= state_d;
      interrupt  <= interrupt_d;
      pending    <= pending_d;
      mask       <= mask_d;
      in_service <= in_service_d;
    end
  end

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Interrupt controller sitting directly upstream of the control FSM. It synchronises external interrupt lines, latches rising edges as pending requests and applies a per-source enable mask. It presents the highest-priority enabled request to the FSM as an encoded number on `interrupt`, which the FSM turns into a vector address of 7 × code. It holds that code stable until the FSM's `processing_interrupt` handshake completes.

## Interface
- `INTERRUPT_WIDTH`, default 4: width of the encoded `interrupt` output; must match the FSM parameter.
- `NUM_SOURCES`, default 15: number of request lines; legal range 1 .. 2**INTERRUPT_WIDTH−1.

Clocking and reset (already decided): one clock; reset is asynchronous and active-low.

- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `irq_in` in NUM_SOURCES: raw request lines, asynchronous, edge-triggered on rising edge.
- `processing_interrupt` in 1: from the FSM; rises on acknowledge, falls at return-from-interrupt.
- `mask_we` in 1: write strobe for the enable mask.
- `mask_data` in NUM_SOURCES: new mask value; 1 means the source is enabled.
- `interrupt` out INTERRUPT_WIDTH: encoded request to the FSM; 0 means none, source i is code i+1.
- `pending` out NUM_SOURCES: latched, unserviced edges.
- `mask` out NUM_SOURCES: current enable mask.
- `in_service` out 1: high while an acknowledged interrupt is being handled.

## Operation
- Reset values: `interrupt`=0, `pending`=0, `mask`=0 (all sources disabled), `in_service`=0, state IDLE, synchroniser flops 0.
- Edge detect: `pending[i]` is set on a synchronised 0→1 of `irq_in[i]`, whether or not the source is masked.
- Masking: only `pending & mask` is eligible for selection.
- Priority: the lowest index wins (source 0 is highest priority). The selected code is the index + 1.
- Mask write: `mask` <= `mask_data` on an edge where `mask_we`=1. It takes effect on the next selection only and never alters a presented code.
- States (encoding in the package):
  - IDLE: `interrupt`=0. If `processing_interrupt`=0 and any eligible bit is set, register the selected code onto `interrupt` and go to PRESENT. If `processing_interrupt`=1 (e.g. reset while the FSM is mid-handler), stay in IDLE.
  - PRESENT: hold `interrupt`. When `processing_interrupt`=1, clear `pending` of the presented source, set `in_service`=1 and go to IN_SERVICE. A new higher-priority edge or a mask clear does not pre-empt; the code stays stable.
  - IN_SERVICE: hold `interrupt` unchanged, because the FSM reads the code one cycle after acknowledge to form the vector. When `processing_interrupt`=0, drive `interrupt`=0 and `in_service`=0, and go to IDLE.
- Simultaneous new edge and acknowledge-clear on the same bit: set wins, and the request stays pending.
- Repeated edges on a bit that is already pending collapse into one request; no counting.
- Invalid state encoding: recover to IDLE with `interrupt`=0.

## Timing
- With `IRQ_SYNC_EN`: `irq_in` high before edge E1 gives `pending` set after E3 and `interrupt` valid after E4.
- Without `IRQ_SYNC_EN`: `pending` set after E2 and `interrupt` valid after E3.
- Acknowledge: `processing_interrupt` high before edge A1 gives `pending` cleared and `in_service`=1 after A1.
- Release: `processing_interrupt` low before edge R1 gives `interrupt`=0 after R1. The earliest next presentation is after R2, a minimum one-cycle gap with code 0.
- Throughput: at most one interrupt per FSM handler; there is no nesting.

## Configuration
- `IRQ_SYNC_EN` defined: two-flop synchroniser per line, plus a delay flop for edge detection.
- `IRQ_SYNC_EN` undefined: a single input register plus the delay flop, for use when `irq_in` is already synchronous to `clk`. Latency drops by one cycle; all other behaviour is identical.

## Structure
- Shared package holds:
  - `irqc_state_t` (IDLE, PRESENT, IN_SERVICE);
  - a constant `IRQ_CODE_NONE` = 0;
  - a function mapping source index to code.
- Natural sub-module: `irq_edge_sync`, one instance per line, carrying the synchroniser (`IRQ_SYNC_EN`-dependent) and emitting a one-cycle rise pulse.
- The top level holds the pending, mask, priority encoder and state register.

## Test plan
- Reset with `mask`=0, pulse `irq_in[2]`: `pending`=0x0004 after 3 edges, `interrupt` stays 0.
- Write `mask`=0x7FFF, then raise `irq_in[2]`: `interrupt`=3 after E4. Raise `processing_interrupt`: `pending[2]`=0, `interrupt` holds 3. Drop it: `interrupt`=0 after one edge.
- With `irq_in[5]` and `irq_in[1]` rising together: `interrupt`=2 first. After release, one cycle at 0, then `interrupt`=6.
- During PRESENT with code 6, raise `irq_in[0]` and clear `mask`: `interrupt` stays 6 until release, then `interrupt`=1 after the gap once the mask is re-enabled.
- Edge on the in-service source in the same cycle as acknowledge: `pending` bit remains 1 and the source is re-presented after release.
- Assert `rst_n`=0 mid-IN_SERVICE with `processing_interrupt` still 1: all outputs 0 immediately; no presentation until `processing_interrupt` falls.
